pg_param_writer: RTL and testbench
==================================

Name: pg_param_writer

Overview:
Initiator side of the profile_gen parameter bus. It accepts 64-bit parameter commands over a valid/ready stream, and serialises each one into per-half writes on param_addr/param_in/param_write_lo/param_write_hi. On request it then issues a paced single-cycle acc_step pulse. It sits between the host command FIFO and one profile_gen instance, replacing hand-driven parameter sequencing.

Parameters:
ADDR_W, 8, width of param_addr / cmd_addr
STEP_GAP, 100, minimum cycles between rising edges of consecutive acc_step pulses (>=2)
MERGE_EQ, 1, when 1, a mask=11 write with equal halves is issued as one cycle with both strobes
CNT_W, 16, width of steps_issued counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  writer can accept a command
cmd_addr  in  ADDR_W  parameter index
cmd_data  in  64  parameter value; [31:0] lo half, [63:32] hi half
cmd_mask  in  2  bit0 = write lo half, bit1 = write hi half
cmd_step  in  1  issue acc_step after the writes
param_addr  out  ADDR_W  to profile_gen
param_in  out  32  to profile_gen
param_write_lo  out  1  lo-half write strobe
param_write_hi  out  1  hi-half write strobe
acc_step  out  1  step pulse to profile_gen
busy  out  1  high in every state except IDLE
steps_issued  out  CNT_W  count of acc_step pulses, wraps modulo 2^CNT_W

Behaviour:
- All outputs are registered. While rst is low: every output is 0, state is IDLE, and the pacer counter is saturated at STEP_GAP.
- cmd_ready goes to 1 on the first clk edge after rst is released. A command is accepted on an edge where cmd_valid and cmd_ready are both 1. cmd_ready is 0 from the accept edge until the command completes. There is no back-to-back accept, so the maximum rate is one command per 2 cycles.
- The accept edge latches addr, data, mask and step, and selects the next state:
  - MERGE_EQ=1, mask=11 and data[63:32]==data[31:0] -> WR_BOTH
  - otherwise, mask[0] -> WR_LO
  - otherwise, mask[1] -> WR_HI
  - otherwise, step -> STEP_WAIT
  - otherwise -> IDLE, and cmd_ready returns 1 on the next edge (no-op command)
- WR_LO: exactly one cycle, with param_write_lo=1 and param_in=data[31:0]. Next state is WR_HI if mask[1]; else STEP_WAIT if step; else DONE.
- WR_HI: exactly one cycle, with param_write_hi=1 and param_in=data[63:32]. Next state is STEP_WAIT if step, else DONE.
- WR_BOTH: exactly one cycle with both strobes high. Next state follows the same rule as WR_HI.
- Strobe outputs are set on the edge that enters the state, so profile_gen samples them on the following edge.
- Outside write states, param_addr and param_in hold their last value and both strobes are 0.
- DONE: cmd_ready=1 in this cycle. The state behaves as IDLE, so an accept is legal here.
- Pacer: gap_cnt resets to 0 on each acc_step and increments each cycle, saturating at STEP_GAP.
- STEP_WAIT: stays in this state while gap_cnt < STEP_GAP-1. Then acc_step=1 for exactly one cycle (STEP) and the state moves to DONE.
  - Two pulses are therefore never less than STEP_GAP cycles apart.
  - The first pulse after reset is not delayed.
- steps_issued increments on each acc_step pulse.
- Reset mid-operation: asynchronous clear. Any pending write or step is dropped with no partial strobe. The next command must be reissued.
- The command is sampled only at accept; input changes afterwards are ignored.

Decomposition:
- Shared package pg_pkg holds: ADDR_W default, mask bit positions (MASK_LO=0, MASK_HI=1), the state encoding (IDLE, WR_LO, WR_HI, WR_BOTH, STEP_WAIT, STEP, DONE) and the command field widths. profile_gen and its bench reuse these.
- One sub-module, pg_step_pacer: gap counter plus a "ready to step" flag, parameterised by STEP_GAP. It is reusable by other step sources.

Test Plan:
- Reset: hold rst=0 for 3 cycles and release. All outputs are 0 during reset, cmd_ready=1 one edge after release, and steps_issued=0.
- Split write: addr=3, data=0x00000001_00000003, mask=11, step=0.
  - Cycle 1 after accept: write_lo=1, param_in=3, addr=3.
  - Cycle 2: write_hi=1, param_in=1.
  - cmd_ready=1 in cycle 3.
- Merge write: MERGE_EQ=1, addrs 0..5, data=0, mask=11. Each command gives one cycle with both strobes and param_in=0, one command per 2 cycles. With MERGE_EQ=0, each command takes 2 write cycles instead.
- Lo-only write: addr=5, data=5, mask=01. There is exactly one write_lo cycle with param_in=5, and write_hi never asserts.
- Step pacing: STEP_GAP=100, three back-to-back step-only commands (mask=00, step=1).
  - The first acc_step fires 2 cycles after accept.
  - Subsequent pulses are exactly 100 cycles apart, each 1 cycle wide.
  - steps_issued=3 at the end.
- Reset mid-write: drive rst=0 in the WR_LO cycle of a mask=11 command. Outputs clear immediately, and no write_hi or acc_step appears after release.

Source files
------------

// File: rtl/pg_pkg.sv
// rtl/pg_pkg.sv - shared constants, state encoding and helpers for the profile_gen parameter bus
package pg_pkg;

  localparam int PG_ADDR_W = 8;
  localparam int DATA_W    = 64;
  localparam int HALF_W    = 32;
  localparam int MASK_W    = 2;
  localparam int MASK_LO   = 0;
  localparam int MASK_HI   = 1;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] WR_LO     = 3'd1;
  localparam logic [STATE_W-1:0] WR_HI     = 3'd2;
  localparam logic [STATE_W-1:0] WR_BOTH   = 3'd3;
  localparam logic [STATE_W-1:0] STEP_WAIT = 3'd4;
  localparam logic [STATE_W-1:0] STEP      = 3'd5;
  localparam logic [STATE_W-1:0] DONE      = 3'd6;

  // Only the parts of a command still needed after the accept edge.
  typedef struct packed {
    logic [HALF_W-1:0] hi;
    logic              wr_hi;
    logic              step;
  } pg_pending_t;

  function automatic logic [STATE_W-1:0] pg_first_state(
    input logic              merge_eq,
    input logic [MASK_W-1:0] mask,
    input logic [DATA_W-1:0] data,
    input logic              step
  );
    logic [STATE_W-1:0] st;
    if (merge_eq && (&mask) && (data[DATA_W-1:HALF_W] == data[HALF_W-1:0]))
      st = WR_BOTH;
    else if (mask[MASK_LO])
      st = WR_LO;
    else if (mask[MASK_HI])
      st = WR_HI;
    else if (step)
      st = STEP_WAIT;
    else
      st = IDLE;
    return st;
  endfunction

  function automatic logic [STATE_W-1:0] pg_after_hi(input logic step);
    return step ? STEP_WAIT : DONE;
  endfunction

endpackage

// File: rtl/pg_param_writer_if.sv
// rtl/pg_param_writer_if.sv - parameter command stream from the host FIFO into pg_param_writer
interface pg_param_writer_if
  import pg_pkg::*;
#(
  parameter int ADDR_W = PG_ADDR_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [MASK_W-1:0] cmd_mask;
  logic              cmd_step;

  modport master (
    output cmd_valid, cmd_addr, cmd_data, cmd_mask, cmd_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, cmd_mask, cmd_step,
    output cmd_ready
  );

endinterface

// File: rtl/pg_step_pacer.sv
// rtl/pg_step_pacer.sv - enforces a minimum spacing between step pulses
module pg_step_pacer #(
  parameter int STEP_GAP = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  output logic ready
);

  localparam int GAP_W = $clog2(STEP_GAP + 1);

  logic [GAP_W-1:0] gap_cnt;

  // Starts saturated so the first step after reset is not held back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt <= GAP_W'(STEP_GAP);
    end else if (fire) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GAP_W'(STEP_GAP)) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  assign ready = (gap_cnt >= GAP_W'(STEP_GAP - 1));

endmodule

// File: rtl/pg_param_writer.sv
// rtl/pg_param_writer.sv - serialises 64-bit parameter commands into half writes and paced acc_step pulses
module pg_param_writer
  import pg_pkg::*;
#(
  parameter int ADDR_W   = PG_ADDR_W,
  parameter int STEP_GAP = 100,
  parameter bit MERGE_EQ = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  pg_param_writer_if.slave   cmd,
  output logic [ADDR_W-1:0]  param_addr,
  output logic [HALF_W-1:0]  param_in,
  output logic               param_write_lo,
  output logic               param_write_hi,
  output logic               acc_step,
  output logic               busy,
  output logic [CNT_W-1:0]   steps_issued
);

  logic [STATE_W-1:0] state, state_nxt;
  logic               ready;
  logic               accept;
  logic               fire;
  logic               step_ready;
  logic [ADDR_W-1:0]  pend_addr;
  pg_pending_t        pend;
  logic [ADDR_W-1:0]  wr_addr;
  logic [HALF_W-1:0]  hi_src;

  assign cmd.cmd_ready = ready;
  assign accept        = cmd.cmd_valid && ready;
  assign fire          = (state_nxt == STEP);

  // Writes entered on the accept edge take fields straight from the bus.
  assign wr_addr = accept ? cmd.cmd_addr : pend_addr;
  assign hi_src  = accept ? cmd.cmd_data[DATA_W-1:HALF_W] : pend.hi;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? pg_first_state(MERGE_EQ, cmd.cmd_mask,
                                                      cmd.cmd_data, cmd.cmd_step)
                                     : IDLE;
      WR_LO:      state_nxt = pend.wr_hi ? WR_HI : pg_after_hi(pend.step);
      WR_HI,
      WR_BOTH:    state_nxt = pg_after_hi(pend.step);
      STEP_WAIT:  state_nxt = step_ready ? STEP : STEP_WAIT;
      STEP:       state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so strobes line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      ready          <= 1'b0;
      pend_addr      <= '0;
      pend           <= '0;
      param_addr     <= '0;
      param_in       <= '0;
      param_write_lo <= 1'b0;
      param_write_hi <= 1'b0;
      acc_step       <= 1'b0;
      busy           <= 1'b0;
      steps_issued   <= '0;
    end else begin
      state <= state_nxt;
      ready <= !accept && ((state_nxt == IDLE) || (state_nxt == DONE));
      if (accept) begin
        pend_addr  <= cmd.cmd_addr;
        pend.hi    <= cmd.cmd_data[DATA_W-1:HALF_W];
        pend.wr_hi <= cmd.cmd_mask[MASK_HI];
        pend.step  <= cmd.cmd_step;
      end
      param_write_lo <= (state_nxt == WR_LO) || (state_nxt == WR_BOTH);
      param_write_hi <= (state_nxt == WR_HI) || (state_nxt == WR_BOTH);
      if ((state_nxt == WR_LO) || (state_nxt == WR_BOTH)) begin
        param_addr <= wr_addr;
        param_in   <= cmd.cmd_data[HALF_W-1:0];
      end else if (state_nxt == WR_HI) begin
        param_addr <= wr_addr;
        param_in   <= hi_src;
      end
      acc_step <= fire;
      busy     <= (state_nxt != IDLE);
      if (fire) begin
        steps_issued <= steps_issued + CNT_W'(1);
      end
    end
  end

  pg_step_pacer #(
    .STEP_GAP (STEP_GAP)
  ) u_pacer (
    .clk   (clk),
    .rst   (rst),
    .fire  (fire),
    .ready (step_ready)
  );

endmodule

// File: tb/tb_pg_param_writer.sv
// tb/tb_pg_param_writer.sv - randomized self-checking bench for pg_param_writer against a timeline model
module tb_pg_param_writer;

  localparam int ADDR_W   = 8;
  localparam int STEP_GAP = 100;
  localparam int CNT_W    = 16;
  localparam int BOUND    = 400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pg_param_writer_if #(.ADDR_W(ADDR_W)) cmd_bus ();
  pg_param_writer_if #(.ADDR_W(ADDR_W)) cmd_bus0 ();

  logic [ADDR_W-1:0] param_addr, param_addr0;
  logic [31:0]       param_in, param_in0;
  logic              wlo, whi, acc, busy;
  logic              wlo0, whi0, acc0, busy0;
  logic [CNT_W-1:0]  steps, steps0;

  pg_param_writer #(.ADDR_W(ADDR_W), .STEP_GAP(STEP_GAP), .MERGE_EQ(1'b1), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .cmd(cmd_bus),
    .param_addr(param_addr), .param_in(param_in),
    .param_write_lo(wlo), .param_write_hi(whi),
    .acc_step(acc), .busy(busy), .steps_issued(steps)
  );

  pg_param_writer #(.ADDR_W(ADDR_W), .STEP_GAP(STEP_GAP), .MERGE_EQ(1'b0), .CNT_W(CNT_W)) u_dut0 (
    .clk(clk), .rst(rst), .cmd(cmd_bus0),
    .param_addr(param_addr0), .param_in(param_in0),
    .param_write_lo(wlo0), .param_write_hi(whi0),
    .acc_step(acc0), .busy(busy0), .steps_issued(steps0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Timeline model: expected events keyed by the cycle (edges since time 0) they are visible in.
  bit                exp_lo[int];
  bit                exp_hi[int];
  bit                exp_step[int];
  bit                exp_busy[int];
  logic [31:0]       exp_data[int];
  logic [ADDR_W-1:0] exp_addr[int];
  int last_pulse = -100000;
  int rdy_from   = 1 << 30;
  int mdl_steps  = 0;
  int pulse_q[$];

  task automatic model_reset();
    exp_lo.delete(); exp_hi.delete(); exp_step.delete(); exp_busy.delete();
    exp_data.delete(); exp_addr.delete();
    last_pulse = -100000;
    rdy_from   = 1 << 30;
    mdl_steps  = 0;
  endtask

  task automatic predict(input int n, input logic [ADDR_W-1:0] addr, input logic [63:0] data,
                         input logic [1:0] mask, input bit step);
    int c;
    int p;
    int rdy;
    bit merge;
    c = n;
    merge = (mask == 2'b11) && (data[63:32] == data[31:0]);
    if (merge) begin
      exp_lo[c] = 1; exp_hi[c] = 1; exp_data[c] = data[31:0]; exp_addr[c] = addr; c++;
    end else begin
      if (mask[0]) begin exp_lo[c] = 1; exp_data[c] = data[31:0];  exp_addr[c] = addr; c++; end
      if (mask[1]) begin exp_hi[c] = 1; exp_data[c] = data[63:32]; exp_addr[c] = addr; c++; end
    end
    if (step) begin
      p = (c + 1 > last_pulse + STEP_GAP) ? c + 1 : last_pulse + STEP_GAP;
      exp_step[p] = 1;
      last_pulse  = p;
      rdy = p + 1;
    end else if (c > n) begin
      rdy = c;
    end else begin
      rdy = n + 1;
    end
    if ((c > n) || step)
      for (int k = n; k <= rdy; k++) exp_busy[k] = 1;
    rdy_from = rdy;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cyc > 0)
        check_eq("reset_outputs", {wlo, whi, acc, busy, cmd_bus.cmd_ready, param_addr, param_in, steps}, 64'd0);
    end else begin
      if (exp_step.exists(cyc)) mdl_steps++;
      if (acc === 1'b1) pulse_q.push_back(cyc);
      check_eq("write_lo", wlo, exp_lo.exists(cyc));
      check_eq("write_hi", whi, exp_hi.exists(cyc));
      check_eq("acc_step", acc, exp_step.exists(cyc));
      check_eq("busy", busy, exp_busy.exists(cyc));
      check_eq("cmd_ready", cmd_bus.cmd_ready, cyc >= rdy_from);
      check_eq("steps_issued", steps, mdl_steps[CNT_W-1:0]);
      if (exp_lo.exists(cyc) || exp_hi.exists(cyc)) begin
        check_eq("param_in", param_in, exp_data[cyc]);
        check_eq("param_addr", param_addr, exp_addr[cyc]);
      end
    end
  end

  int cnt_lo0 = 0, cnt_hi0 = 0, cnt_both0 = 0;
  always @(negedge clk) begin
    if (rst) begin
      cnt_lo0   += int'(wlo0);
      cnt_hi0   += int'(whi0);
      cnt_both0 += int'(wlo0 & whi0);
    end
  end

  // Driver stays on the posedge+2 phase; returns with n = accept edge, or -1 on timeout.
  task automatic send(input logic [ADDR_W-1:0] addr, input logic [63:0] data,
                      input logic [1:0] mask, input bit step, output int n);
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_addr = addr; cmd_bus.cmd_data = data;
    cmd_bus.cmd_mask  = mask; cmd_bus.cmd_step = step;
    for (int k = 0; k < BOUND && !cmd_bus.cmd_ready; k++) begin
      @(posedge clk); #2;
    end
    n = -1;
    if (!cmd_bus.cmd_ready) begin
      check_eq("accept_timeout", cmd_bus.cmd_ready, 1'b1);
    end else begin
      n = cyc + 1;
      @(posedge clk); #2;
      predict(n, addr, data, mask, step);
    end
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_addr  = ADDR_W'($urandom);
    cmd_bus.cmd_data  = {$urandom, $urandom};
    cmd_bus.cmd_mask  = 2'($urandom);
    cmd_bus.cmd_step  = 1'($urandom);
  endtask

  task automatic send0(input logic [ADDR_W-1:0] addr);
    cmd_bus0.cmd_valid = 1'b1; cmd_bus0.cmd_addr = addr; cmd_bus0.cmd_data = 64'd0;
    cmd_bus0.cmd_mask  = 2'b11; cmd_bus0.cmd_step = 1'b0;
    for (int k = 0; k < BOUND && !cmd_bus0.cmd_ready; k++) begin
      @(posedge clk); #2;
    end
    if (!cmd_bus0.cmd_ready) check_eq("accept0_timeout", cmd_bus0.cmd_ready, 1'b1);
    else begin @(posedge clk); #2; end
    cmd_bus0.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < BOUND && !cmd_bus.cmd_ready; k++) begin
      @(posedge clk); #2;
    end
    if (!cmd_bus.cmd_ready) check_eq("idle_timeout", cmd_bus.cmd_ready, 1'b1);
  endtask

  initial begin
    int n;
    int n0;
    int prev_n;
    int pb;
    logic [31:0] d32;
    logic [63:0] d;
    cmd_bus.cmd_valid  = 1'b0; cmd_bus.cmd_addr  = '0; cmd_bus.cmd_data  = '0;
    cmd_bus.cmd_mask   = '0;   cmd_bus.cmd_step  = 1'b0;
    cmd_bus0.cmd_valid = 1'b0; cmd_bus0.cmd_addr = '0; cmd_bus0.cmd_data = '0;
    cmd_bus0.cmd_mask  = '0;   cmd_bus0.cmd_step = 1'b0;

    // Reset: three cycles low, ready one edge after release.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    rdy_from = cyc + 1;
    @(posedge clk); #2;
    check_eq("ready_after_release", cmd_bus.cmd_ready, 1'b1);
    check_eq("steps_after_reset", steps, 0);

    // Split write.
    send(8'd3, 64'h00000001_00000003, 2'b11, 1'b0, n);
    check_eq("split_c1_lo", {wlo, whi}, 2'b10);
    check_eq("split_c1_data", param_in, 32'd3);
    check_eq("split_c1_addr", param_addr, 8'd3);
    @(posedge clk); #2;
    check_eq("split_c2_hi", {wlo, whi}, 2'b01);
    check_eq("split_c2_data", param_in, 32'd1);
    @(posedge clk); #2;
    check_eq("split_c3_ready", cmd_bus.cmd_ready, 1'b1);

    // Merged writes, one command every 2 cycles.
    prev_n = -1;
    for (int a = 0; a < 6; a++) begin
      send(ADDR_W'(a), 64'd0, 2'b11, 1'b0, n);
      check_eq("merge_both", {wlo, whi}, 2'b11);
      if (prev_n >= 0) check_eq("merge_rate", n - prev_n, 2);
      prev_n = n;
    end

    // Lo-only write.
    send(8'd5, 64'd5, 2'b01, 1'b0, n);
    check_eq("lo_only_strobes", {wlo, whi}, 2'b10);
    check_eq("lo_only_data", param_in, 32'd5);

    // Step pacing with three back-to-back step-only commands.
    wait_ready();
    pb = pulse_q.size();
    send(8'd0, 64'd0, 2'b00, 1'b1, n0);
    send(8'd0, 64'd0, 2'b00, 1'b1, n);
    send(8'd0, 64'd0, 2'b00, 1'b1, n);
    wait_ready();
    check_eq("pace_pulses", pulse_q.size() - pb, 3);
    if (pulse_q.size() - pb >= 3) begin
      check_eq("pace_first", pulse_q[pb], n0 + 1);
      check_eq("pace_gap1", pulse_q[pb+1] - pulse_q[pb], STEP_GAP);
      check_eq("pace_gap2", pulse_q[pb+2] - pulse_q[pb+1], STEP_GAP);
    end
    check_eq("pace_steps", steps, 3);

    // Randomized commands.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
      d32 = $urandom;
      d = ($urandom_range(0, 3) == 0) ? {d32, d32} : {$urandom, $urandom};
      send(ADDR_W'($urandom), d, 2'($urandom), ($urandom_range(0, 3) == 0), n);
    end
    wait_ready();

    // Reset in the WR_LO cycle of a split write with step.
    send(8'd7, 64'h12345678_9abcdef0, 2'b11, 1'b1, n);
    rst = 1'b0;
    #1;
    check_eq("midreset_clear", {wlo, whi, acc, busy, cmd_bus.cmd_ready, steps}, 64'd0);
    model_reset();
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b1;
    rdy_from = cyc + 1;
    pb = pulse_q.size();
    repeat (150) begin @(posedge clk); #2; end
    check_eq("midreset_no_step", pulse_q.size() - pb, 0);

    // MERGE_EQ=0 instance: equal halves still take two write cycles.
    for (int a = 0; a < 6; a++) send0(ADDR_W'(a));
    repeat (4) begin @(posedge clk); #2; end
    check_eq("nomerge_lo", cnt_lo0, 6);
    check_eq("nomerge_hi", cnt_hi0, 6);
    check_eq("nomerge_both", cnt_both0, 0);
    check_eq("nomerge_addr", param_addr0, 8'd5);
    check_eq("nomerge_data", param_in0, 32'd0);
    check_eq("nomerge_idle", {busy0, acc0, steps0}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
